// File: rtl/ahb_slave_mem_if.sv
// AHB-Lite segment signals between a master and the ahb_slave_mem responder.
interface ahb_slave_mem_if;
   logic        Hsel;
   logic        Hreadyin;
   logic [1:0]  Htrans;
   logic        Hwrite;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic [31:0] Hrdata;
   logic [1:0]  Hresp;
   logic        Hready_out;

   modport master (
      output Hsel, Hreadyin, Htrans, Hwrite, Haddr, Hwdata,
      input  Hrdata, Hresp, Hready_out
   );

   modport slave (
      input  Hsel, Hreadyin, Htrans, Hwrite, Haddr, Hwdata,
      output Hrdata, Hresp, Hready_out
   );
endinterface

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave over a DEPTH-word memory; data phase follows the address phase after WAIT_STATES stall cycles.
// Stalls the bus via Hready_out; define AHBS_ERR_EN to answer out-of-range addresses with a two-cycle ERROR.
module ahb_slave_mem #(
   parameter int unsigned DEPTH       = 16,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic           Hclk,
   input  logic           Hreset,
   ahb_slave_mem_if.slave bus
);
   localparam int         IW = $clog2(DEPTH);
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

   state_t        state;
   logic [3:0]    wait_cnt;
   logic [IW-1:0] idx_q;
   logic          write_q;
   logic          in_range_q;
   logic [31:0]   mem [DEPTH];

   logic [32:0]   offset;
   logic [32:0]   word_idx;
   logic          in_range;
   logic [IW-1:0] idx_new;
   logic          can_accept;
   logic          accept;
   logic          err_take;
   logic          wr_commit;
   logic [31:0]   rd_new;

   // 33-bit offset so addresses below BASE_ADDR cannot wrap into range
   always_comb begin
      offset   = {1'b0, bus.Haddr} - {1'b0, BASE_ADDR};
      word_idx = offset >> 2;
      in_range = (bus.Haddr >= BASE_ADDR) && (word_idx < 33'(DEPTH));
      idx_new  = word_idx[IW-1:0];
   end

   assign can_accept = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
   assign accept     = can_accept && bus.Hsel && bus.Hreadyin && bus.Htrans[1];
   assign wr_commit  = (state == S_DATA) && write_q && in_range_q;

`ifdef AHBS_ERR_EN
   assign err_take = !in_range;
`else
   assign err_take = 1'b0;
`endif

   // A zero-wait read right behind a write to the same word sees the data being committed now
   always_comb begin
      rd_new = 32'h0;
      if (in_range) begin
         if (wr_commit && (idx_q == idx_new))
            rd_new = bus.Hwdata;
         else
            rd_new = mem[idx_new];
      end
   end

   always_ff @(posedge Hclk) begin
      if (!Hreset && wr_commit)
         mem[idx_q] <= bus.Hwdata;
   end

   always_ff @(posedge Hclk) begin
      if (Hreset) begin
         state          <= S_IDLE;
         wait_cnt       <= 4'd0;
         idx_q          <= '0;
         write_q        <= 1'b0;
         in_range_q     <= 1'b0;
         bus.Hready_out <= 1'b1;
         bus.Hresp      <= RESP_OKAY;
         bus.Hrdata     <= 32'h0;
      end else begin
         case (state)
            S_WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state          <= S_DATA;
                  bus.Hready_out <= 1'b1;
                  if (!write_q)
                     bus.Hrdata <= in_range_q ? mem[idx_q] : 32'h0;
               end
            end
            S_ERR1: begin
               state          <= S_ERR2;
               bus.Hready_out <= 1'b1;
               bus.Hresp      <= RESP_ERROR;
            end
            default: begin
               if (accept) begin
                  idx_q      <= idx_new;
                  write_q    <= bus.Hwrite;
                  in_range_q <= in_range;
                  if (err_take) begin
                     state          <= S_ERR1;
                     bus.Hready_out <= 1'b0;
                     bus.Hresp      <= RESP_ERROR;
                  end else if (WS != 4'd0) begin
                     state          <= S_WAIT;
                     wait_cnt       <= WS;
                     bus.Hready_out <= 1'b0;
                     bus.Hresp      <= RESP_OKAY;
                  end else begin
                     state          <= S_DATA;
                     bus.Hready_out <= 1'b1;
                     bus.Hresp      <= RESP_OKAY;
                     if (!bus.Hwrite)
                        bus.Hrdata <= rd_new;
                  end
               end else begin
                  state          <= S_IDLE;
                  bus.Hready_out <= 1'b1;
                  bus.Hresp      <= RESP_OKAY;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ahb_slave_mem.sv
`timescale 1ns/1ps
// Two responders (zero-wait at base 0, two-wait at base 0x100) under random AHB traffic, checked every
// cycle against a transaction-level model of expected Hready_out/Hresp/Hrdata; builds with or without AHBS_ERR_EN.
module tb_ahb_slave_mem;
   localparam int unsigned DEP0  = 16;
   localparam int unsigned DEP1  = 8;
   localparam logic [31:0] BASE0 = 32'h0000_0000;
   localparam logic [31:0] BASE1 = 32'h0000_0100;
   localparam int unsigned WS0   = 0;
   localparam int unsigned WS1   = 2;
   localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

   typedef struct {
      logic        rdy;
      logic [1:0]  resp;
      logic        ld;
      logic [31:0] val;
   } exp_t;

   logic Hclk = 1'b0;
   always #5 Hclk = ~Hclk;

   logic        rst   [2];
   logic        sel   [2];
   logic        wr    [2];
   logic        hold  [2];
   logic [1:0]  trans [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];

   ahb_slave_mem_if bus0 ();
   ahb_slave_mem_if bus1 ();

   assign bus0.Hsel     = sel[0];
   assign bus0.Htrans   = trans[0];
   assign bus0.Hwrite   = wr[0];
   assign bus0.Haddr    = addr[0];
   assign bus0.Hwdata   = wdata[0];
   assign bus0.Hreadyin = bus0.Hready_out & ~hold[0];
   assign bus1.Hsel     = sel[1];
   assign bus1.Htrans   = trans[1];
   assign bus1.Hwrite   = wr[1];
   assign bus1.Haddr    = addr[1];
   assign bus1.Hwdata   = wdata[1];
   assign bus1.Hreadyin = bus1.Hready_out & ~hold[1];

   ahb_slave_mem #(.DEPTH(DEP0), .BASE_ADDR(BASE0), .WAIT_STATES(WS0)) dut0 (
      .Hclk(Hclk), .Hreset(rst[0]), .bus(bus0.slave));
   ahb_slave_mem #(.DEPTH(DEP1), .BASE_ADDR(BASE1), .WAIT_STATES(WS1)) dut1 (
      .Hclk(Hclk), .Hreset(rst[1]), .bus(bus1.slave));

   exp_t        q0 [$];
   exp_t        q1 [$];
   logic [31:0] mm [2][16];
   logic [31:0] last_rd [2];
   int          total = 0;
   int          bad = 0;

   function automatic logic get_rdy(input int k);
      return (k == 0) ? bus0.Hready_out : bus1.Hready_out;
   endfunction
   function automatic logic [1:0] get_resp(input int k);
      return (k == 0) ? bus0.Hresp : bus1.Hresp;
   endfunction
   function automatic logic [31:0] get_rdat(input int k);
      return (k == 0) ? bus0.Hrdata : bus1.Hrdata;
   endfunction
   function automatic logic [31:0] base_of(input int k);
      return (k == 0) ? BASE0 : BASE1;
   endfunction
   function automatic int dep_of(input int k);
      return (k == 0) ? int'(DEP0) : int'(DEP1);
   endfunction
   function automatic int ws_of(input int k);
      return (k == 0) ? int'(WS0) : int'(WS1);
   endfunction
   function automatic logic [31:0] pat(input int k, input int i);
      return 32'hC000_0000 + (32'(k) << 24) + 32'(i);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int k, input exp_t e);
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic sync();
      @(posedge Hclk);
      #1;
   endtask

   task automatic idle(input int k, input int n);
      sel[k] = 1'b0;
      trans[k] = T_IDLE;
      repeat (n) sync();
   endtask

   // Present one address phase, wait for it to be taken, and record the response the bus must see.
   task automatic xfer(input int k, input logic [1:0] t, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input bit drop);
      longint off;
      bit     inr;
      bit     err;
      int     idx;
      exp_t   e;
      sel[k] = s; trans[k] = t; wr[k] = w; addr[k] = a;
      @(negedge Hclk);
      for (int n = 0; get_rdy(k) !== 1'b1; n++) begin
         if (n == 40) begin
            check($sformatf("dut%0d ready timeout", k), 32'(get_rdy(k)), 32'd1);
            break;
         end
         @(negedge Hclk);
      end
      @(posedge Hclk);
      if (s && t[1]) begin
         off = longint'(a) - longint'(base_of(k));
         inr = (off >= 0) && (off < 4 * longint'(dep_of(k)));
         idx = inr ? int'(off / 4) : 0;
         err = 1'b0;
`ifdef AHBS_ERR_EN
         err = !inr;
`endif
         if (err) begin
            push(k, '{1'b0, 2'b01, 1'b0, 32'h0});
            push(k, '{1'b1, 2'b01, 1'b0, 32'h0});
         end else begin
            for (int i = 0; i < ws_of(k); i++) push(k, '{1'b0, 2'b00, 1'b0, 32'h0});
            e = '{1'b1, 2'b00, !w, (inr ? mm[k][idx] : 32'h0)};
            push(k, e);
            if (w && inr && !drop) mm[k][idx] = d;
         end
      end
      #1;
      sel[k] = 1'b0;
      trans[k] = T_IDLE;
      if (s && t[1] && w) wdata[k] = d;
   endtask

   task automatic init_mem(input int k);
      for (int i = 0; i < dep_of(k); i++)
         xfer(k, (i == 0) ? T_NSEQ : T_SEQ, 1'b1, 1'b1, base_of(k) + 32'(4 * i), pat(k, i), 1'b0);
      idle(k, 2);
   endtask

   task automatic directed0();
      xfer(0, T_NSEQ, 1'b1, 1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0);
      xfer(0, T_NSEQ, 1'b1, 1'b0, 32'h08, 32'h0, 1'b0);
      @(negedge Hclk);
      check("b2b read data", get_rdat(0), 32'hDEAD_BEEF);
      check("b2b read ready", 32'(get_rdy(0)), 32'd1);
      sync();
      sel[0] = 1'b1; trans[0] = T_BUSY; wr[0] = 1'b1; addr[0] = 32'h0C; wdata[0] = 32'h1234;
      sync();
      sel[0] = 1'b0; trans[0] = T_NSEQ;
      sync();
      idle(0, 1);
      xfer(0, T_NSEQ, 1'b1, 1'b0, 32'h0C, 32'h0, 1'b0);
      @(negedge Hclk);
      check("busy/desel word3", get_rdat(0), 32'hC000_0003);
      check("busy/desel resp", 32'(get_resp(0)), 32'd0);
      sync();
      xfer(0, T_NSEQ, 1'b1, 1'b1, 32'h40, 32'h5555_5555, 1'b0);
`ifdef AHBS_ERR_EN
      @(negedge Hclk);
      check("err1 ready", 32'(get_rdy(0)), 32'd0);
      check("err1 resp", 32'(get_resp(0)), 32'd1);
      @(negedge Hclk);
      check("err2 ready", 32'(get_rdy(0)), 32'd1);
      check("err2 resp", 32'(get_resp(0)), 32'd1);
      sync();
`else
      xfer(0, T_NSEQ, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
      @(negedge Hclk);
      check("oor read data", get_rdat(0), 32'h0);
      check("oor read resp", 32'(get_resp(0)), 32'd0);
      sync();
`endif
      xfer(0, T_NSEQ, 1'b1, 1'b0, 32'h00, 32'h0, 1'b0);
      @(negedge Hclk);
      check("word0 after oor write", get_rdat(0), 32'hC000_0000);
      sync();
   endtask

   task automatic directed1();
      xfer(1, T_NSEQ, 1'b1, 1'b0, BASE1 + 32'h04, 32'h0, 1'b0);
      @(negedge Hclk);
      check("ws2 ready c1", 32'(get_rdy(1)), 32'd0);
      @(negedge Hclk);
      check("ws2 ready c2", 32'(get_rdy(1)), 32'd0);
      @(negedge Hclk);
      check("ws2 ready c3", 32'(get_rdy(1)), 32'd1);
      check("ws2 read data", get_rdat(1), 32'hC100_0001);
      sync();
      xfer(1, T_NSEQ, 1'b1, 1'b1, BASE1 + 32'h10, 32'hBAD0_0010, 1'b1);
      rst[1] = 1'b1;
      sync();
      rst[1] = 1'b0;
      @(negedge Hclk);
      check("reset mid ready", 32'(get_rdy(1)), 32'd1);
      check("reset mid resp", 32'(get_resp(1)), 32'd0);
      check("reset mid rdata", get_rdat(1), 32'h0);
      sync();
      xfer(1, T_NSEQ, 1'b1, 1'b0, BASE1 + 32'h10, 32'h0, 1'b0);
      repeat (3) @(negedge Hclk);
      check("dropped write word4", get_rdat(1), 32'hC100_0004);
      sync();
   endtask

   task automatic random_ops(input int k, input int n);
      for (int j = 0; j < n; j++) begin
         int          r;
         logic [31:0] a;
         r = int'($urandom_range(0, 11));
         case ($urandom_range(0, 7))
            0:       a = base_of(k) - 32'($urandom_range(1, 16));
            1:       a = base_of(k) + 32'(4 * dep_of(k)) + 32'($urandom_range(0, 63));
            default: a = base_of(k) + 32'($urandom_range(0, 4 * dep_of(k) - 1));
         endcase
         if (r < 2) begin
            idle(k, int'($urandom_range(1, 2)));
         end else if (r == 2) begin
            xfer(k, ($urandom_range(0, 1) != 0) ? T_BUSY : T_IDLE, 1'b1, 1'b1, a, $urandom, 1'b0);
         end else if (r == 3) begin
            xfer(k, T_NSEQ, 1'b0, 1'b1, a, $urandom, 1'b0);
         end else if (r == 4) begin
            // address phase while another slave holds the bus: must not be taken
            idle(k, ws_of(k) + 1);
            sel[k] = 1'b1; trans[k] = T_NSEQ; wr[k] = 1'b1; addr[k] = a; hold[k] = 1'b1;
            sync();
            hold[k] = 1'b0;
            idle(k, 1);
         end else begin
            xfer(k, (r % 2 != 0) ? T_NSEQ : T_SEQ, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
         end
      end
   endtask

   initial begin : compare
      logic rst_edge [2];
      exp_t e;
      forever begin
         @(posedge Hclk);
         rst_edge[0] = rst[0];
         rst_edge[1] = rst[1];
         @(negedge Hclk);
         for (int k = 0; k < 2; k++) begin
            e = '{1'b1, 2'b00, 1'b0, 32'h0};
            if (rst_edge[k]) begin
               if (k == 0) q0.delete();
               else q1.delete();
               last_rd[k] = 32'h0;
            end else if (k == 0 && q0.size() > 0) begin
               e = q0.pop_front();
            end else if (k == 1 && q1.size() > 0) begin
               e = q1.pop_front();
            end
            if (e.ld) last_rd[k] = e.val;
            check($sformatf("dut%0d Hready_out", k), 32'(get_rdy(k)), 32'(e.rdy));
            check($sformatf("dut%0d Hresp", k), 32'(get_resp(k)), 32'(e.resp));
            check($sformatf("dut%0d Hrdata", k), get_rdat(k), last_rd[k]);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   initial begin : main
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; sel[k] = 1'b0; wr[k] = 1'b0; hold[k] = 1'b0;
         trans[k] = T_IDLE; addr[k] = 32'h0; wdata[k] = 32'h0; last_rd[k] = 32'h0;
      end
      repeat (2) @(posedge Hclk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge Hclk);
      for (int k = 0; k < 2; k++) begin
         check($sformatf("reset dut%0d ready", k), 32'(get_rdy(k)), 32'd1);
         check($sformatf("reset dut%0d resp", k), 32'(get_resp(k)), 32'd0);
         check($sformatf("reset dut%0d rdata", k), get_rdat(k), 32'h0);
      end
      sync();
      fork
         begin
            init_mem(0);
            directed0();
            random_ops(0, 300);
            idle(0, 4);
         end
         begin
            init_mem(1);
            directed1();
            random_ops(1, 300);
            idle(1, 4);
         end
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
